// File: rtl/sys_timer_pkg.sv
// Shared definitions for the multi-channel millisecond timer: register
// offsets within the mapper window, ctrl bit positions and the ctrl struct.
package sys_timer_pkg;

    // Free-running counter registers
    localparam logic [7:0] REG_MS_LO = 8'h00;
    localparam logic [7:0] REG_MS_HI = 8'h01;

    // Channel n occupies CH_BASE + CH_STRIDE*n .. +3
    localparam int CH_BASE   = 4;
    localparam int CH_STRIDE = 4;

    // Offsets inside one channel block
    localparam logic [1:0] CH_RLD_LO = 2'd0;
    localparam logic [1:0] CH_RLD_HI = 2'd1;
    localparam logic [1:0] CH_CTRL   = 2'd2;
    localparam logic [1:0] CH_STAT   = 2'd3;

    // Ctrl register bit positions
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_PERIODIC_BIT = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;

    typedef struct packed {
        logic irq_en;
        logic periodic;
        logic en;
    } ch_ctrl_t;

    // Unpack a written ctrl byte; unused bits are dropped.
    function automatic ch_ctrl_t ctrl_from_byte(input logic [7:0] b);
        ch_ctrl_t c;
        c.irq_en   = b[CTRL_IRQ_EN_BIT];
        c.periodic = b[CTRL_PERIODIC_BIT];
        c.en       = b[CTRL_EN_BIT];
        return c;
    endfunction

    // Present ctrl on the bus; unused bits read as 0.
    function automatic logic [7:0] ctrl_to_byte(input ch_ctrl_t c);
        logic [7:0] b;
        b = 8'h00;
        b[CTRL_IRQ_EN_BIT]   = c.irq_en;
        b[CTRL_PERIODIC_BIT] = c.periodic;
        b[CTRL_EN_BIT]       = c.en;
        return b;
    endfunction

endpackage

// File: rtl/sys_timer_ch.sv
// One countdown channel: reload, count, count-hi read snapshot, ctrl and the
// sticky expired flag. Exposes next-state irq so the top can register it.
module sys_timer_ch
    import sys_timer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       i_rst,
    input  logic       i_tick,
    input  logic       i_wr_stb,
    input  logic       i_rd_stb,
    input  logic       i_sel,
    input  logic [1:0] i_reg_off,
    input  logic [7:0] i_din,
    output logic [7:0] o_rdata,
    output logic       o_irq_next
);

    logic [CNT_W-1:0] r_reload;
    logic [CNT_W-1:0] r_count;
    logic [7:0]       r_cnt_hi_snap;
    ch_ctrl_t         r_ctrl;
    logic             r_expired;

    logic [CNT_W-1:0] w_reload_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [7:0]       w_snap_nxt;
    ch_ctrl_t         w_ctrl_nxt;
    logic             w_expired_nxt;

    // 16-bit views; bits above CNT_W are structurally zero
    logic [15:0] w_reload_16;
    logic [15:0] w_count_16;
    logic [15:0] w_rld_lo_val;
    logic [15:0] w_rld_hi_val;

    assign w_reload_16  = 16'(r_reload);
    assign w_count_16   = 16'(r_count);
    assign w_rld_lo_val = {w_reload_16[15:8], i_din};
    assign w_rld_hi_val = {i_din, w_reload_16[7:0]};

    logic w_wr_rld_lo, w_wr_rld_hi, w_wr_ctrl, w_wr_stat, w_rd_lo;
    assign w_wr_rld_lo = i_wr_stb && i_sel && (i_reg_off == CH_RLD_LO);
    assign w_wr_rld_hi = i_wr_stb && i_sel && (i_reg_off == CH_RLD_HI);
    assign w_wr_ctrl   = i_wr_stb && i_sel && (i_reg_off == CH_CTRL);
    assign w_wr_stat   = i_wr_stb && i_sel && (i_reg_off == CH_STAT);
    assign w_rd_lo     = i_rd_stb && i_sel && (i_reg_off == CH_RLD_LO);

    // Next-state for the whole channel: bus writes, then countdown on tick
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        w_reload_nxt  = r_reload;
        w_count_nxt   = r_count;
        w_snap_nxt    = r_cnt_hi_snap;
        w_ctrl_nxt    = r_ctrl;
        w_expired_nxt = r_expired;

        if (w_wr_rld_lo) w_reload_nxt = w_rld_lo_val[CNT_W-1:0];
        if (w_wr_rld_hi) w_reload_nxt = w_rld_hi_val[CNT_W-1:0];

        // Clear is applied before the countdown so a same-clk expiry wins
        if (w_wr_stat && i_din[0]) w_expired_nxt = 1'b0;

        if (w_wr_ctrl) begin
            // A ctrl write owns this clk; the tick is ignored here
            w_ctrl_nxt = ctrl_from_byte(i_din);
            if (i_din[CTRL_EN_BIT] && !r_ctrl.en) w_count_nxt = r_reload;
        end else if (i_tick && r_ctrl.en) begin
            if (r_count > CNT_W'(1)) begin
                w_count_nxt = r_count - CNT_W'(1);
            end else begin
                // count of 0 or 1 expires; a reload of 0 therefore acts as 1
                w_expired_nxt = 1'b1;
                if (r_ctrl.periodic) begin
                    w_count_nxt = r_reload;
                end else begin
                    w_count_nxt   = '0;
                    w_ctrl_nxt.en = 1'b0;
                end
            end
        end

        if (w_rd_lo) w_snap_nxt = w_count_16[15:8];
    end

    // Channel state registers
    always_ff @(posedge clk or posedge i_rst) begin
        // NOTE: every channel register is a plain flop with a defined reset
        // value, and sequential state is always updated with <= so all flops
        // sample the same pre-edge values.
        if (i_rst) begin
            r_reload      <= '0;
            r_count       <= '0;
            r_cnt_hi_snap <= 8'h00;
            r_ctrl        <= '0;
            r_expired     <= 1'b0;
        end else begin
            r_reload      <= w_reload_nxt;
            r_count       <= w_count_nxt;
            r_cnt_hi_snap <= w_snap_nxt;
            r_ctrl        <= w_ctrl_nxt;
            r_expired     <= w_expired_nxt;
        end
    end

    // Read mux for this channel's four offsets
    always_comb begin
        o_rdata = 8'h00;
        case (i_reg_off)
            CH_RLD_LO: o_rdata = w_count_16[7:0];
            CH_RLD_HI: o_rdata = r_cnt_hi_snap;
            CH_CTRL:   o_rdata = ctrl_to_byte(r_ctrl);
            CH_STAT:   o_rdata = {7'b0, r_expired};
            default:   o_rdata = 8'h00;
        endcase
    end

    assign o_irq_next = w_expired_nxt & w_ctrl_nxt.irq_en;

endmodule

// File: rtl/sys_timer_mc.sv
// Multi-channel millisecond timer behind the mapper register window.
// Holds the tick prescaler, the 16-bit free-running ms counter with its
// lo-read/hi-snapshot scheme, channel decode, the read mux and the irq OR.
module sys_timer_mc
    import sys_timer_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 1000,
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       sys_rst,
    input  logic       wr_stb,
    input  logic       rd_stb,
    input  logic [7:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq
);

    // DIV must be an integer >= 2
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;

    logic [PW-1:0] r_presc;
    logic [15:0]   r_ms;
    logic [7:0]    r_ms_hi;
    logic          r_irq;

    logic w_tick;
    logic w_ms_wr;
    logic w_ms_rd;

    assign w_tick  = (r_presc == PW'(DIV - 1));
    assign w_ms_wr = wr_stb && (addr == REG_MS_LO);
    assign w_ms_rd = rd_stb && (addr == REG_MS_LO);

    // Prescaler and ms counter; a write to MS_LO beats a same-clk tick
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_presc <= '0;
            r_ms    <= 16'h0000;
        end else if (w_ms_wr) begin
            r_presc <= '0;
            r_ms    <= 16'h0000;
        end else if (w_tick) begin
            r_presc <= '0;
            r_ms    <= r_ms + 16'd1;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Latch ms high byte when the low byte is read, for a coherent pair
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_ms_hi <= 8'h00;
        end else if (w_ms_rd) begin
            r_ms_hi <= r_ms[15:8];
        end
    end

    logic [NUM_CH-1:0] w_ch_sel;
    logic [NUM_CH-1:0] w_ch_irq_next;
    logic [7:0]        w_ch_rdata [NUM_CH];

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            localparam int LO = CH_BASE + CH_STRIDE * g;

            assign w_ch_sel[g] = (addr >= 8'(LO)) && (addr < 8'(LO + CH_STRIDE));

            sys_timer_ch #(
                .CNT_W (CNT_W)
            ) u_ch (
                .clk        (clk),
                .i_rst      (sys_rst),
                .i_tick     (w_tick),
                .i_wr_stb   (wr_stb),
                .i_rd_stb   (rd_stb),
                .i_sel      (w_ch_sel[g]),
                .i_reg_off  (addr[1:0]),
                .i_din      (din),
                .o_rdata    (w_ch_rdata[g]),
                .o_irq_next (w_ch_irq_next[g])
            );
        end
    endgenerate

    // Combinational read mux; unmapped offsets read 0x00
    always_comb begin
        dout = 8'h00;
        case (addr)
            REG_MS_LO: dout = r_ms[7:0];
            REG_MS_HI: dout = r_ms_hi;
            default: begin
                for (int n = 0; n < NUM_CH; n++) begin
                    if (w_ch_sel[n]) dout = w_ch_rdata[n];
                end
            end
        endcase
    end

    // Level irq registered from the channels' next-state flags
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |w_ch_irq_next;
        end
    end

    assign irq = r_irq;

endmodule
